// File: rtl/alu_req_arbiter_pkg.sv
// Shared definitions for the two-requester ALU sequencer: operation codes
// as seen on the ALU select pins and the sequencer state encoding.
package alu_req_arbiter_pkg;

    // Operation codes {S1,S0} exactly as the ALU decodes them.
    typedef enum logic [1:0] {
        OP_ADD = 2'd0,
        OP_SUB = 2'd1,
        OP_CMP = 2'd2,
        OP_AND = 2'd3
    } op_t;

    // Sequencer states; encoding 2'd3 is unused and recovers to IDLE.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/alu_req_arbiter_rr_arbiter2.sv
// Two-input round-robin grant. The priority pointer names the requester that
// wins a tie; on an advance strobe it moves to the requester not just served.
module alu_req_arbiter_rr_arbiter2 #(
    parameter int RR_INIT = 0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    input  logic req0,
    input  logic req1,
    input  logic advance,
    input  logic served_id,
    output logic grant_valid,
    output logic grant_id
);

    localparam logic PTR_INIT = (RR_INIT != 0);

    logic ptr;

    // Priority pointer: hand priority to the other requester after each service.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: state is updated with non-blocking assignments so every flop
        // samples values from before the edge, independent of block order.
        if (!rst_n) begin
            ptr <= PTR_INIT;
        end else if (advance) begin
            ptr <= ~served_id;
        end
    end

    // Grant decode: a lone request wins outright, a tie goes to the pointer.
    always_comb begin
        grant_valid = enable & (req0 | req1);
        grant_id    = (req0 & req1) ? ptr : req1;
    end

endmodule

// File: rtl/alu_req_arbiter.sv
// Shares one 4-bit combinational ALU between two requesters. One operation is
// in flight at a time: accept (IDLE), drive the ALU (EXEC), then hold the
// tagged result on the response channel until it is taken (RESP).
module alu_req_arbiter #(
    parameter int DATA_W  = 4,
    parameter int RR_INIT = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    input  logic [1:0]        req0_op,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [1:0]        req1_op,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    output logic              req1_ready,
    output logic              rsp_valid,
    output logic              rsp_id,
    output logic [DATA_W-1:0] rsp_x,
    output logic              rsp_carry,
    input  logic              rsp_ready,
    output logic              alu_s0,
    output logic              alu_s1,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    input  logic [DATA_W-1:0] alu_x,
    input  logic              alu_carry,
    output logic              busy,
    output logic [7:0]        op_count
);

    import alu_req_arbiter_pkg::*;

    state_t            state;
    state_t            next_state;
    op_t               op_q;
    logic [DATA_W-1:0] a_q;
    logic [DATA_W-1:0] b_q;
    logic              id_q;
    logic              arb_enable;
    logic              grant_valid;
    logic              grant_id;
    logic              accept;
    logic              rsp_fire;

    // Grants are only offered in IDLE, and never while reset is held, so the
    // ready pulses read 0 during reset even with a request pending.
    assign arb_enable = (state == IDLE) & rst_n;

    alu_req_arbiter_rr_arbiter2 #(
        .RR_INIT (RR_INIT)
    ) u_rr (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (arb_enable),
        .req0        (req0_valid),
        .req1        (req1_valid),
        .advance     (rsp_fire),
        .served_id   (id_q),
        .grant_valid (grant_valid),
        .grant_id    (grant_id)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode plus the accept and response-handshake strobes.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves one unassigned, which would otherwise infer a latch.
        next_state = IDLE;
        accept     = 1'b0;
        rsp_fire   = 1'b0;
        case (state)
            IDLE: begin
                if (grant_valid) begin
                    accept     = 1'b1;
                    next_state = EXEC;
                end
            end
            EXEC: begin
                next_state = RESP;
            end
            RESP: begin
                if (rsp_valid && rsp_ready) begin
                    rsp_fire   = 1'b1;
                    next_state = IDLE;
                end else begin
                    next_state = RESP;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Operand registers: capture the granted request; they keep their value
    // afterwards, so the ALU pins are not cleared on return to IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q <= OP_ADD;
            a_q  <= '0;
            b_q  <= '0;
            id_q <= 1'b0;
        end else if (accept) begin
            op_q <= grant_id ? op_t'(req1_op) : op_t'(req0_op);
            a_q  <= grant_id ? req1_a : req0_a;
            b_q  <= grant_id ? req1_b : req0_b;
            id_q <= grant_id;
        end
    end

    // Response registers and completed-operation counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid <= 1'b0;
            rsp_id    <= 1'b0;
            rsp_x     <= '0;
            rsp_carry <= 1'b0;
            op_count  <= 8'd0;
        end else if (state == EXEC) begin
            rsp_valid <= 1'b1;
            rsp_id    <= id_q;
            rsp_x     <= alu_x;
            rsp_carry <= alu_carry;
        end else if (rsp_fire) begin
            rsp_valid <= 1'b0;
            op_count  <= op_count + 8'd1;
        end
    end

    // Ready pulses, busy flag and ALU pins.
    always_comb begin
        req0_ready = accept & ~grant_id;
        req1_ready = accept &  grant_id;
        busy       = (state != IDLE);
        alu_s1     = op_q[1];
        alu_s0     = op_q[0];
        alu_a      = a_q;
        alu_b      = b_q;
    end

endmodule

// File: doc/alu_req_arbiter.md
Name: alu_req_arbiter

Overview:
- Sequencer and arbiter that shares one 4-bit, 4-function combinational ALU between two requesters.
- ALU functions: add, sub, compare, and.
- Accepts one operation at a time with round-robin fairness, drives the ALU select and operand inputs from registers, captures the ALU result and returns it on a shared response channel tagged with the requester ID.
- Sits between the requesting control units and the ALU instance at the next level up.

Parameters:
DATA_W, 4, operand/result width; only 4 is supported, present for port sizing.
RR_INIT, 0, requester that holds priority after reset (0 or 1).

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
req0_valid  input  1  requester 0 has an operation pending
req0_op  input  2  operation code {S1,S0}: 0 add, 1 sub, 2 compare, 3 and
req0_a  input  DATA_W  operand A
req0_b  input  DATA_W  operand B
req0_ready  output  1  one-cycle accept pulse to requester 0
req1_valid  input  1  as req0
req1_op  input  2  as req0
req1_a  input  DATA_W  as req0
req1_b  input  DATA_W  as req0
req1_ready  output  1  as req0
rsp_valid  output  1  response available
rsp_id  output  1  requester that owns the response
rsp_x  output  DATA_W  result word
rsp_carry  output  1  carry flag from the ALU
rsp_ready  input  1  response consumer accepts
alu_s0  output  1  ALU select bit 0
alu_s1  output  1  ALU select bit 1
alu_a  output  DATA_W  ALU operand A
alu_b  output  DATA_W  ALU operand B
alu_x  input  DATA_W  ALU result
alu_carry  input  1  ALU carry
busy  output  1  high in any state other than IDLE
op_count  output  8  completed-operation counter

Behaviour:
- Clock and reset: one clock (clk); reset rst_n is asynchronous and active-low.
- Reset values:
  - State IDLE, priority pointer = RR_INIT.
  - Operand and op registers 0, so alu_s0/alu_s1/alu_a/alu_b = 0.
  - rsp_valid/rsp_id/rsp_x/rsp_carry = 0.
  - req0_ready/req1_ready = 0, busy = 0, op_count = 0.
- State IDLE:
  - If any reqN_valid is high, grant it. If both are high, grant the requester named by the pointer.
  - Assert reqN_ready for exactly this cycle. At the clock edge, latch op/a/b and grant ID. Go to EXEC.
  - If no request is valid, stay in IDLE.
- State EXEC:
  - ALU inputs are driven from the latched registers: alu_s1 = op[1], alu_s0 = op[0].
  - At the end of the cycle, register alu_x/alu_carry into rsp_x/rsp_carry. Set rsp_valid = 1 and rsp_id = grant ID. Go to RESP.
- State RESP:
  - Hold rsp_* stable while rsp_ready is low.
  - On the cycle where rsp_valid and rsp_ready are both high:
    - Clear rsp_valid at the edge.
    - Increment op_count; 8-bit, wraps 255 -> 0.
    - Set the pointer to the requester not just served.
    - Return to IDLE.
- Latency and throughput:
  - Accept in cycle N, rsp_valid high in cycle N+2.
  - Back-to-back operations issue at most once every 3 cycles: accept, exec, resp with rsp_ready already high.
  - No request is accepted in EXEC or RESP; both reqN_ready stay low there.
- Request protocol: the requester holds valid/op/a/b stable until it sees ready. The arbiter samples only in the IDLE grant cycle.
- Compare result: rsp_x = {0, lesser, equal, greater} as returned by the ALU.
- Carry: rsp_carry is passed through unchanged for all ops; the ALU forces it to 0 for compare and and.
- Operand registers keep their last value after the response; alu_* are not cleared in IDLE.
- rsp_ready high before rsp_valid has no effect.
- Reset asserted in EXEC or RESP: the in-flight operation is dropped and no response is produced. All outputs take their reset values immediately, independent of clk.
- Illegal states decode to IDLE.

Decomposition:
- Shared package: op-code constants (OP_ADD = 2'd0, OP_SUB = 2'd1, OP_CMP = 2'd2, OP_AND = 2'd3) and state encoding (IDLE, EXEC, RESP, 2-bit).
- Natural sub-module: rr_arbiter2, a 2-input round-robin grant with pointer update on an "advance" strobe.
- FSM, operand registers and response registers stay in the top module.

Test Plan:
- Add from requester 0: after reset, req0 valid with op=0, a=5, b=3 -> req0_ready pulses one cycle, rsp_valid two cycles later, rsp_id=0, rsp_x=8, rsp_carry=0, op_count=1.
- Carry: req1 op=0, a=9, b=8 -> rsp_x=1, rsp_carry=1, rsp_id=1.
- Simultaneous requests with RR_INIT=0: both valid in the same cycle (req0 and, 7 & 12; req1 compare, 7 vs 7) -> req0 served first with rsp_x=4, then req1 with rsp_x=2 (equal); a third simultaneous pair is served req0 first again.
- Backpressure: hold rsp_ready low 5 cycles in RESP -> rsp_valid/rsp_x/rsp_id stable, both reqN_ready low, busy=1; raise rsp_ready -> IDLE next cycle.
- Mid-operation reset: assert rst_n low during EXEC -> rsp_valid=0, busy=0, alu_* = 0, op_count=0 immediately; no response after release.
- Counter wrap: complete 256 operations -> op_count reads 0 after the 256th handshake.
